// File: rtl/fft_pkg.sv
// fft_pkg: sizes, types and helpers shared by the FFT datapath
package fft_pkg;
  localparam int width = 16;
  localparam int N_2 = 5;
  localparam int N = 1 << N_2;
  localparam int sw = $clog2(N_2 + 1);
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  typedef struct packed {
    logic signed [width-1:0] re;
    logic signed [width-1:0] im;
  } complex_t;
  function automatic logic [N_2-1:0] bitrev(input logic [N_2-1:0] x);
    for (int i = 0; i < N_2; i++) bitrev[i] = x[N_2-1-i];
  endfunction
  function automatic logic [width-1:0] sin_q(input logic [3:0] i);
    case (i)
      4'd0: return 16'h0000;
      4'd1: return 16'h18F8;
      4'd2: return 16'h30FB;
      4'd3: return 16'h471C;
      4'd4: return 16'h5A81;
      4'd5: return 16'h6A6C;
      4'd6: return 16'h7640;
      4'd7: return 16'h7D89;
      4'd8: return 16'h7FFF;
      default: return '0;
    endcase
  endfunction
  function automatic logic [2*width-1:0] twiddle_of(input logic [N_2-2:0] adr);
    int k;
    complex_t w;
    k = int'(adr) << (5 - N_2);
    w.re = k <= 8 ? sin_q(4'(8 - k)) : -sin_q(4'(k - 8));
    w.im = k <= 8 ? -sin_q(4'(k)) : -sin_q(4'(16 - k));
    return w;
  endfunction
endpackage

// File: rtl/fft_agu.sv
// fft_agu: transform sequencing and RAM/twiddle address generation
module fft_agu
  import fft_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           load,
  output logic           done,
  output logic           rdsel,
  output logic           we0,
  output logic [N_2-1:0] adr0a,
  output logic [N_2-1:0] adr0b,
  output logic           we1,
  output logic [N_2-1:0] adr1a,
  output logic [N_2-1:0] adr1b,
  output logic [N_2-2:0] twiddleadr
);
  state_t state, state_n;
  logic [sw-1:0] stage;
  logic [N_2-2:0] bfly, mask, pos;
  logic [N_2-1:0] loadcnt, outcnt, ia, ib;
  logic compute, last;
  // state register
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // next state: load wins over everything, start is only heard outside COMPUTE
  always_comb begin
    compute = state == COMPUTE;
    last = compute && stage == sw'(N_2 - 1) && &bfly;
    state_n = load ? IDLE : last ? DONE : !compute && start ? COMPUTE : state;
  end
  // sample/output pointers and butterfly position, held at zero outside COMPUTE
  always_ff @(posedge clk)
    if (!reset) begin
      loadcnt <= '0;
      outcnt <= '0;
      stage <= '0;
      bfly <= '0;
    end else begin
      loadcnt <= load ? loadcnt + N_2'(1) : state == IDLE && start ? '0 : loadcnt;
      outcnt <= state == DONE && !load ? outcnt + N_2'(1) : '0;
      stage <= compute ? stage + sw'(&bfly) : '0;
      bfly <= compute ? bfly + (N_2-1)'(1) : '0;
    end
  // top leg inserts a 0 at bit 'stage' of bfly, bottom leg sits 2**stage above; even stages read bank0
  always_comb begin
    mask = (N_2-1)'((1 << stage) - 1);
    pos = bfly & mask;
    ia = {bfly & ~mask, 1'b0} | {1'b0, pos};
    ib = ia | N_2'(1 << stage);
    twiddleadr = pos << (N_2 - 1 - int'(stage));
    done = state == DONE;
    rdsel = N_2 % 2 == 1;
    we0 = load || compute && stage[0];
    we1 = compute && !stage[0];
    adr0a = load ? bitrev(loadcnt) : done ? outcnt : ia;
    adr0b = ib;
    adr1a = done ? outcnt : ia;
    adr1b = ib;
  end
endmodule

// File: rtl/fft_butterfly.sv
// fft_butterfly: radix-2 DIT butterfly, aout = a + b*w, bout = a - b*w
module fft_butterfly
  import fft_pkg::*;
(
  input  logic [2*width-1:0] twiddle,
  input  logic [2*width-1:0] a,
  input  logic [2*width-1:0] b,
  output logic [2*width-1:0] aout,
  output logic [2*width-1:0] bout
);
  localparam int w2 = 2 * width;
  complex_t tw, ac, bc, p, x, y;
  logic signed [w2-1:0] pr, pi;
  // full-precision complex product, floor back to Q1.15, then wrap-around add/subtract
  always_comb begin
    tw = twiddle;
    ac = a;
    bc = b;
    pr = w2'(bc.re) * w2'(tw.re) - w2'(bc.im) * w2'(tw.im);
    pi = w2'(bc.re) * w2'(tw.im) + w2'(bc.im) * w2'(tw.re);
    p.re = width'(pr >>> (width - 1));
    p.im = width'(pi >>> (width - 1));
    x.re = ac.re + p.re;
    x.im = ac.im + p.im;
    y.re = ac.re - p.re;
    y.im = ac.im - p.im;
    aout = x;
    bout = y;
  end
endmodule

// File: rtl/fft.sv
// fft: in-place radix-2 DIT FFT over ping-pong RAM banks, one butterfly per cycle
module fft
  import fft_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               load,
  input  logic [width-1:0]   rd,
  output logic [2*width-1:0] wd,
  output logic               done
);
  logic rdsel, we0, we1;
  logic [N_2-1:0] adr0a, adr0b, adr1a, adr1b;
  logic [N_2-2:0] twiddleadr;
  logic [2*width-1:0] twiddle, a, b, aout, bout;
  logic [2*width-1:0] ram0 [N];
  logic [2*width-1:0] ram1 [N];
  fft_agu agu (
    .clk(clk),
    .reset(reset),
    .start(start),
    .load(load),
    .done(done),
    .rdsel(rdsel),
    .we0(we0),
    .adr0a(adr0a),
    .adr0b(adr0b),
    .we1(we1),
    .adr1a(adr1a),
    .adr1b(adr1b),
    .twiddleadr(twiddleadr)
  );
  fft_butterfly bf (
    .twiddle(twiddle),
    .a(a),
    .b(b),
    .aout(aout),
    .bout(bout)
  );
  // twiddle ROM, operands from the ping bank, results from the final bank
  always_comb begin
    twiddle = twiddle_of(twiddleadr);
    a = we1 ? ram0[adr0a] : ram1[adr1a];
    b = we1 ? ram0[adr0b] : ram1[adr1b];
    wd = rdsel ? ram1[adr1a] : ram0[adr0a];
  end
  // loads land in bank0, butterfly results in the pong bank
  always_ff @(posedge clk) begin
    if (we0) ram0[adr0a] <= load ? {rd, {width{1'b0}}} : aout;
    if (we0 && !load) ram0[adr0b] <= bout;
    if (we1) begin
      ram1[adr1a] <= aout;
      ram1[adr1b] <= bout;
    end
  end
endmodule

// File: tb/tb_fft.sv
// tb_fft: bench for fft and fft_butterfly against a floating-point-twiddle DIT model
module tb_fft;
  import fft_pkg::*;
  localparam real pi_c = 3.14159265358979323846;
  logic clk = 0;
  logic reset, start, load;
  logic [15:0] rd;
  logic [31:0] wd;
  logic done;
  logic [31:0] tw, ba, bb, bao, bbo;
  int checks = 0;
  int failures = 0;
  logic signed [15:0] x_in [32];
  logic [31:0] exp_out [32];

  fft dut (.clk(clk), .reset(reset), .start(start), .load(load), .rd(rd), .wd(wd), .done(done));
  fft_butterfly bfu (.twiddle(tw), .a(ba), .b(bb), .aout(bao), .bout(bbo));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int wrap16(input int v);
    return int'(shortint'(v));
  endfunction

  task automatic bfly_ref(input int ar, input int ai, input int br, input int bi, input int tr, input int ti,
                          output int yr, output int yi, output int zr, output int zi);
    int pr, pq;
    pr = wrap16((br * tr - bi * ti) >>> 15);
    pq = wrap16((br * ti + bi * tr) >>> 15);
    yr = wrap16(ar + pr);
    yi = wrap16(ai + pq);
    zr = wrap16(ar - pr);
    zi = wrap16(ai - pq);
  endtask

  task automatic fft_ref();
    int xr [32];
    int xi [32];
    int r, half, k, j, tr, ti, yr, yi, zr, zi;
    real ang;
    for (int i = 0; i < N; i++) begin
      r = 0;
      for (int t = 0; t < N_2; t++) if ((i & (1 << t)) != 0) r |= 1 << (N_2 - 1 - t);
      xr[r] = x_in[i];
      xi[r] = 0;
    end
    for (int s = 0; s < N_2; s++) begin
      half = 1 << s;
      for (int g = 0; g < N; g += 2 * half)
        for (int p = 0; p < half; p++) begin
          k = p * (N / (2 * half));
          ang = 2.0 * pi_c * k / N;
          tr = $rtoi($cos(ang) * 32767.0);
          ti = -$rtoi($sin(ang) * 32767.0);
          j = g + p;
          bfly_ref(xr[j], xi[j], xr[j+half], xi[j+half], tr, ti, yr, yi, zr, zi);
          xr[j] = yr;
          xi[j] = yi;
          xr[j+half] = zr;
          xi[j+half] = zi;
        end
    end
    for (int i = 0; i < N; i++) exp_out[i] = {xr[i][15:0], xi[i][15:0]};
  endtask

  task automatic load_all();
    reset = 0;
    @(posedge clk);
    #1 reset = 1;
    for (int i = 0; i < N; i++) begin
      load = 1;
      rd = x_in[i];
      @(posedge clk);
      #1;
    end
    load = 0;
  endtask

  task automatic run_fft(input string tag, input int restart_at, input bit data);
    int cnt = 0;
    start = 1;
    do begin
      @(posedge clk);
      #1;
      cnt++;
      start = restart_at != 0 && cnt == restart_at;
    end while (!done && cnt < 200);
    start = 0;
    check({tag, "_latency"}, cnt, 81);
    if (data) begin
      for (int i = 0; i <= N; i++) begin
        check($sformatf("%s_bin%0d", tag, i), wd, exp_out[i % N]);
        @(posedge clk);
        #1;
      end
      check({tag, "_done_held"}, done, 1);
    end
  endtask

  initial begin
    int yr, yi, zr, zi;
    reset = 0; start = 0; load = 0; rd = 0; tw = 0; ba = 0; bb = 0;
    repeat (3) @(posedge clk);
    #1 check("reset_done", done, 0);
    reset = 1;
    #1 check("bf_zero_a", bao, 32'h0000_0000);
    check("bf_zero_b", bbo, 32'h0000_0000);
    tw = 32'h7FFF_0000; bb = 32'h7FFF_0000;
    #1 check("bf_unit_a", bao, 32'h7FFE_0000);
    check("bf_unit_b", bbo, 32'h8002_0000);
    tw = 32'h471C_6A6C; ba = 32'h1234_1234; bb = 32'h3FFF_3FFF;
    #1 check("bf_mix_a", bao, 32'h008C_6AF6);
    check("bf_mix_b", bbo, 32'h23DC_B972);
    for (int n = 0; n < 25; n++) begin
      tw = $urandom; ba = $urandom; bb = $urandom;
      #1;
      bfly_ref($signed(ba[31:16]), $signed(ba[15:0]), $signed(bb[31:16]), $signed(bb[15:0]),
               $signed(tw[31:16]), $signed(tw[15:0]), yr, yi, zr, zi);
      check("bf_rand_a", bao, {yr[15:0], yi[15:0]});
      check("bf_rand_b", bbo, {zr[15:0], zi[15:0]});
    end
    for (int i = 0; i < N; i++) begin
      x_in[i] = 0;
      exp_out[i] = 32'h4000_0000;
    end
    x_in[0] = 16'h4000;
    load_all();
    run_fft("impulse", 0, 1);
    for (int i = 0; i < N; i++) begin
      x_in[i] = 0;
      exp_out[i] = 32'h0000_0000;
    end
    load_all();
    run_fft("zero", 0, 1);
    for (int i = 0; i < N; i++) x_in[i] = 16'($urandom_range(0, 4095) - 2048);
    fft_ref();
    load_all();
    run_fft("rand_small", 0, 1);
    for (int i = 0; i < N; i++) x_in[i] = 16'($urandom);
    fft_ref();
    load_all();
    run_fft("rand_full", 0, 1);
    for (int i = 0; i < N; i++) x_in[i] = 16'($urandom_range(0, 8191) - 4096);
    fft_ref();
    load_all();
    run_fft("start_in_compute", 10, 1);
    run_fft("restart_from_done", 0, 0);
    load = 1; rd = 0;
    @(posedge clk);
    #1 load = 0;
    check("load_clears_done", done, 0);
    repeat (100) @(posedge clk);
    #1 check("load_stays_idle", done, 0);
    load_all();
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (20) @(posedge clk);
    #1 reset = 0;
    @(posedge clk);
    #1 reset = 1;
    check("reset_mid_done", done, 0);
    repeat (100) @(posedge clk);
    #1 check("reset_mid_idle", done, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
